store_rmw_ctrl: RTL

- Multicycle store sequencer between the datapath store request and data memory.
- Partial stores (byte/half) run as read-modify-write: fetch the memory word, latch it, replace the low lane(s) with the register operand, write the word back.
- Word stores skip the read.
- Stalls the control unit through busy and signals completion with a done pulse.

---
 rtl/store_pkg.sv | 30 +++
 rtl/store_merge.sv | 13 +
 rtl/store_rmw_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared encodings and lane-merge helper for the store read-modify-write sequencer.
package store_pkg;

  localparam logic [1:0] SZ_ILL  = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // Register low lane(s) replace the low lane(s) of the fetched word; no shift on addr[1:0].
  function automatic logic [31:0] merge_word(input logic [31:0] memo,
                                             input logic [31:0] data,
                                             input logic [1:0]  size);
    logic [31:0] w_word;
    case (size)
      SZ_BYTE: w_word = {memo[31:8], data[7:0]};
      SZ_HALF: w_word = {memo[31:16], data[15:0]};
      default: w_word = data;
    endcase
    return w_word;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge of the fetched memory word with the store operand.
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] i_memo,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  output logic [31:0] o_wdata
);

  assign o_wdata = merge_word(i_memo, i_data, i_size);

endmodule

// File: rtl/store_rmw_ctrl.sv
// Multicycle store sequencer: partial stores run read-modify-write, word stores write directly.
module store_rmw_ctrl
  import store_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_data,
  input  logic [1:0]        i_req_size,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  localparam int unsigned CNT_W = 3;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_size;
  logic [31:0]       r_memo;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_wdata;
  logic [31:0]       w_merged;
  logic              w_accept;

  store_merge u_merge (
    .i_memo  (r_memo),
    .i_data  (r_data),
    .i_size  (r_size),
    .o_wdata (w_merged)
  );

  assign w_accept   = (r_state == IDLE) && i_req && (i_req_size != SZ_ILL);
  assign o_busy     = (r_state != IDLE);
  assign o_mem_addr = r_addr;

  always_comb begin
    w_state_nxt = r_state;
    o_mem_wr    = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_mem_wdata = r_wdata;
    unique case (r_state)
      IDLE: begin
        if (i_req) begin
          if (i_req_size == SZ_ILL) begin
            w_state_nxt = ERR;
          end else if (i_req_size == SZ_WORD) begin
            w_state_nxt = WRITE;
          end else begin
            w_state_nxt = READ;
          end
        end
      end
      READ: begin
        if (r_cnt == '0) begin
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        o_mem_wr    = 1'b1;
        o_mem_wdata = w_merged;
        w_state_nxt = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      ERR: begin
        o_err       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= '0;
      r_memo  <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= i_req_addr;
        r_data <= i_req_data;
        r_size <= i_req_size;
        r_cnt  <= CNT_W'(MEM_LAT - 1);
      end
      if (r_state == READ) begin
        if (r_cnt == '0) begin
          r_memo <= i_mem_rdata;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      // mem_wdata keeps showing the last written word once WRITE is left.
      if (r_state == WRITE) begin
        r_wdata <= w_merged;
      end
    end
  end

endmodule
